// File: rtl/fft_peak_tracker_if.sv
// Frame-in / result-out bundle between the FFT magnitude stage, the peak tracker and the display logic.
interface fft_peak_tracker_if;
    logic        clear;
    logic [71:0] mag_in;
    logic        mag_valid;
    logic        busy;
    logic [2:0]  peak_bin;
    logic [8:0]  peak_mag;
    logic        out_valid;
    logic        overrun;

    modport master (
        output clear, mag_in, mag_valid,
        input  busy, peak_bin, peak_mag, out_valid, overrun
    );

    modport slave (
        input  clear, mag_in, mag_valid,
        output busy, peak_bin, peak_mag, out_valid, overrun
    );
endinterface

// File: rtl/fft_peak_tracker.sv
// Exponentially averaged spectrum over bins 0..4 with a one-bin-per-clock scan that
// reports the dominant bin and its averaged magnitude once per accepted frame.
module fft_peak_tracker #(
    parameter int AVG_SHIFT = 2,
    parameter bit SKIP_DC   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    fft_peak_tracker_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [2:0] FIRST_IDX = SKIP_DC ? 3'd1 : 3'd0;
    localparam logic [2:0] LAST_IDX  = 3'd4;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [8:0]        shadow_q [5];
    logic [8:0]        avg_q [5];
    logic [8:0]        avg_d [5];
    logic [2:0]        best_bin_q, best_bin_d;
    logic [8:0]        best_mag_q, best_mag_d;
    logic [2:0]        peak_bin_q, peak_bin_d;
    logic [8:0]        peak_mag_q, peak_mag_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic              shadow_load;

    logic [8:0]        cur_mag, cur_avg, new_avg;
    logic signed [9:0] diff, step;

    // Mirrored bins 5..7 and the step sign bit are intentionally not consumed.
    logic unused_bits;
    assign unused_bits = ^{bus.mag_in[71:45], step[9]};

    // The averaged result always stays inside 0..511, so modulo-512 addition of the
    // low step bits gives the exact new average without saturation.
    always_comb begin
        cur_mag = shadow_q[idx_q];
        cur_avg = avg_q[idx_q];
        diff    = $signed({1'b0, cur_mag}) - $signed({1'b0, cur_avg});
        step    = diff >>> AVG_SHIFT;
        new_avg = cur_avg + step[8:0];
    end

    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        avg_d       = avg_q;
        best_bin_d  = best_bin_q;
        best_mag_d  = best_mag_q;
        peak_bin_d  = peak_bin_q;
        peak_mag_d  = peak_mag_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        shadow_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mag_valid) begin
                    shadow_load = 1'b1;
                    idx_d       = FIRST_IDX;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                avg_d[idx_q] = new_avg;
                if (idx_q == FIRST_IDX || new_avg > best_mag_q) begin
                    best_bin_d = idx_q;
                    best_mag_d = new_avg;
                end
                // Last bin: publish the result including this bin's update.
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    peak_bin_d  = best_bin_d;
                    peak_mag_d  = best_mag_d;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
                if (bus.mag_valid) overrun_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                if (bus.mag_valid) overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (bus.clear) begin
            state_d     = IDLE;
            avg_d       = '{default: '0};
            overrun_d   = 1'b0;
            out_valid_d = 1'b0;
            shadow_load = 1'b0;
            peak_bin_d  = peak_bin_q;
            peak_mag_d  = peak_mag_q;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values; blocking is reserved for the combinational blocks above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            avg_q       <= '{default: '0};
            best_bin_q  <= 3'd0;
            best_mag_q  <= 9'd0;
            peak_bin_q  <= 3'd0;
            peak_mag_q  <= 9'd0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            avg_q       <= avg_d;
            best_bin_q  <= best_bin_d;
            best_mag_q  <= best_mag_d;
            peak_bin_q  <= peak_bin_d;
            peak_mag_q  <= peak_mag_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: the shadow frame has no reset; it is always loaded before SCAN reads it.
    always_ff @(posedge clk) begin
        if (shadow_load) begin
            for (int k = 0; k < 5; k++) begin
                shadow_q[k] <= bus.mag_in[9*k +: 9];
            end
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.peak_bin  = peak_bin_q;
    assign bus.peak_mag  = peak_mag_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: doc/fft_peak_tracker.md
# fft_peak_tracker

Downstream consumer of the 8-point FFT magnitude stage. Takes one frame of eight 9-bit bin magnitudes, keeps an exponentially averaged spectrum for the non-mirrored bins 0..4, and reports the dominant bin and its averaged magnitude once per frame. Bins are scanned sequentially, one per clock. The output feeds the display/pin-mapping logic in the top level.

## Interface
Parameters:
- AVG_SHIFT, 2: IIR smoothing shift. Legal range 0..4. 0 means no averaging, so avg = mag.
- SKIP_DC, 1: when 1, bin 0 is excluded from averaging and the peak search.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of the averages and overrun; aborts any scan.
- mag_in  in  72  frame of magnitudes, unsigned. Bin k is at [9k+8:9k].
- mag_valid  in  1  single-cycle frame strobe.
- busy  out  1  high while a frame is being processed.
- peak_bin  out  3  index of the dominant bin, range 0..4.
- peak_mag  out  9  averaged magnitude of peak_bin.
- out_valid  out  1  one-cycle result strobe.
- overrun  out  1  sticky flag: a frame was dropped.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - When mag_valid=1 and clear=0: latch bins 0..4 of mag_in into a shadow register.
  - Set idx to SKIP_DC (1 if SKIP_DC=1, else 0), then go to SCAN.
  - Bins 5..7 are ignored; they mirror bins 3..1 for real input.
- SCAN, one bin per edge:
  - Compute d = {1'b0,mag[idx]} − {1'b0,avg[idx]}, 10-bit signed.
  - New avg = avg[idx] + (d >>> AVG_SHIFT), arithmetic shift rounding toward −inf. The result always stays within 0..511, so no saturation logic is needed.
  - Write the new avg to avg[idx].
  - On the first scanned bin, load best_bin/best_mag unconditionally. On later bins, replace only if new avg > best_mag (strictly greater). Ties therefore keep the lower index.
  - After idx=4, go to DONE.
- DONE (one cycle):
  - peak_bin and peak_mag are registered with best_bin/best_mag; out_valid=1.
  - Next state is IDLE.
- busy = 1 in SCAN and DONE.
- A mag_valid while busy=1 is dropped and sets overrun=1. A dropped frame is not queued.
- clear=1:
  - Zeroes avg[0..4] and overrun, and forces IDLE. No out_valid is produced for an aborted frame.
  - peak_bin/peak_mag hold their last values.
  - clear has priority over a simultaneous mag_valid, which is ignored and does not set overrun.
- Output hold: peak_bin and peak_mag hold between results and change only on entry to DONE.

## Timing
- Reset (asynchronous assert; deassert synchronised upstream):
  - State IDLE; avg[0..4] = 0.
  - busy=0, peak_bin=0, peak_mag=0, out_valid=0, overrun=0.
- Let N = 5 − SKIP_DC. mag_valid is sampled at edge E0.
  - busy=1 from E0 through the DONE cycle.
  - SCAN edges are E1..EN.
  - out_valid=1 for exactly the cycle after EN.
  - busy=0 after EN+1.
  - Latency from the mag_valid edge to the out_valid cycle is N+1 edges: 5 edges with SKIP_DC=1, 6 edges with SKIP_DC=0.
- Maximum frame rate is one frame per N+2 cycles, because a mag_valid in the DONE cycle counts as an overrun.
- Reset mid-scan immediately returns all outputs and averages to their reset values.

## Test plan
- Reset values: assert rst mid-SCAN → all outputs 0 and busy=0 immediately; the next frame starts from avg=0.
- No averaging (AVG_SHIFT=0, SKIP_DC=1):
  - Frame bins 0..4 = {300,10,90,40,20}, mag_valid at E0 → out_valid in the cycle after E4; peak_bin=2, peak_mag=90. busy is high E0..E5.
- Tie handling (AVG_SHIFT=0, SKIP_DC=0):
  - Frame {50,70,70,10,0} → peak_bin=1, peak_mag=70; out_valid after E5.
  - Repeat with SKIP_DC=1 and bin 0 = 500 → result unchanged.
- Averaging (AVG_SHIFT=2, SKIP_DC=1):
  - Frames with bin2=200 and all other bins 0: first frame → peak_mag=50; second frame → peak_mag=87.
  - A third frame with all bins 0 → bin2 avg = 65, peak_bin=2.
- Overrun:
  - A second mag_valid at E2 → no second out_valid, overrun=1 and sticky.
  - A mag_valid in the DONE cycle also sets overrun.
  - clear=1 → overrun=0.
- Clear mid-scan:
  - clear at E2 of a frame → no out_valid; state IDLE the next cycle; averages 0; peak outputs keep their previous values.
  - A simultaneous clear and mag_valid → frame ignored, overrun stays 0.
